// File: rtl/alu_pkg.sv
// alu_pkg: shared op encodings, FSM states and op legality helper for the serial ALU
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/alu_bit_cell.sv
// alu_bit_cell: combinational 1-bit ALU slice (AND/OR/ADD/SUB/SLT)
//   a, b   : operand bits
//   c_in   : carry into this bit
//   less   : value selected when op[1:0] == 2'b11
//   op     : 3-bit operation; op[2] inverts b for subtraction
//   r      : slice result
//   c_out  : carry out of this bit
//   v, set : overflow and overflow-corrected sign, meaningful only at the MSB
module alu_bit_cell (
    input  logic       a,
    input  logic       b,
    input  logic       c_in,
    input  logic       less,
    input  logic [2:0] op,
    output logic       r,
    output logic       c_out,
    output logic       v,
    output logic       set
);

    logic w_bp;
    logic w_sum;

    always_comb begin
        w_bp  = b ^ op[2];
        w_sum = a ^ w_bp ^ c_in;
        c_out = (a & w_bp) | (c_in & (a ^ w_bp));
        v     = c_in ^ c_out;
        set   = v ^ w_sum;
        r     = (op[1:0] == 2'b00) ? (a & w_bp) :
                (op[1:0] == 2'b01) ? (a | w_bp) :
                (op[1:0] == 2'b10) ? w_sum : less;
    end

endmodule

// File: rtl/alu_serial_engine.sv
// alu_serial_engine: bit-serial ALU, one bit per clock LSB first, start/done handshake
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : request, accepted only in IDLE or DONE
//   op, a, b   : operation and operands, captured on an accepted start
//   busy       : high while bits are being processed
//   done       : one-cycle pulse when result and flags are valid
//   result     : registered result
//   zero       : result == 0
//   overflow   : signed overflow, ADD/SUB only
//   carry_out  : MSB carry out, ADD/SUB/SLT only
module alu_serial_engine
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sh;
    logic [2:0]         r_op;
    logic [CNT_W-1:0]   r_idx;
    logic               r_carry;
    logic               w_accept;
    logic               w_last;
    logic               w_r;
    logic               w_c;
    logic               w_v;
    logic               w_set;
    logic [WIDTH-1:0]   w_shifted;
    logic [WIDTH-1:0]   w_res;

    // operands are shifted right so the active bit is always at index 0
    alu_bit_cell u_cell (
        .a     (r_a[0]),
        .b     (r_b[0]),
        .c_in  (r_carry),
        .less  (1'b0),
        .op    (r_op),
        .r     (w_r),
        .c_out (w_c),
        .v     (w_v),
        .set   (w_set)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        busy     = 1'b0;
        done     = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept = start;
                w_next   = start ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                busy   = 1'b1;
                w_next = w_last ? ST_DONE : ST_RUN;
            end
            ST_DONE: begin
                done     = 1'b1;
                w_accept = start;
                w_next   = start ? ST_RUN : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // the final result includes the MSB bit being processed this cycle
    always_comb begin
        w_last    = (r_idx == CNT_W'(WIDTH - 1));
        w_shifted = {w_r, r_sh[WIDTH-1:1]};
        w_res     = !op_legal(r_op) ? '0 :
                    (r_op == OP_SLT) ? {{(WIDTH-1){1'b0}}, w_set} : w_shifted;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_sh      <= '0;
            r_op      <= '0;
            r_idx     <= '0;
            r_carry   <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            carry_out <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_idx   <= '0;
            r_carry <= op[2];
        end else if (busy) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_sh    <= w_shifted;
            r_carry <= w_c;
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
                result    <= w_res;
                zero      <= (w_res == '0);
                overflow  <= ((r_op == OP_ADD) || (r_op == OP_SUB)) & w_v;
                carry_out <= ((r_op == OP_ADD) || (r_op == OP_SUB) || (r_op == OP_SLT)) & w_c;
            end
        end
    end

endmodule
